// File: rtl/print_uart_tx_if.sv
// Byte stream from the data memory print port into the UART printer.
interface print_uart_tx_if;
   logic       print_valid;
   logic [7:0] print_value;

   modport master (output print_valid, output print_value);
   modport slave  (input  print_valid, input  print_value);
endinterface

// File: rtl/print_uart_tx.sv
// Buffers print bytes in a small FIFO and sends them as 8N1 UART frames.
// Bytes offered while the FIFO is full are dropped and counted.
module print_uart_tx #(
   parameter int CLK_DIV = 868,
   parameter int FIFO_AW = 4
) (
   input  logic        clk,
   input  logic        reset,
   print_uart_tx_if.slave pif,
   output logic        uart_tx,
   output logic        tx_busy,
   output logic        fifo_empty,
   output logic        fifo_full,
   output logic [15:0] drop_cnt
);

   localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
   localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(2**FIFO_AW);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t state;

   logic [7:0]         mem [2**FIFO_AW];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;
   logic [BW-1:0]      baud_cnt;
   logic [2:0]         bit_idx;
   logic [7:0]         shift;
   logic               push;
   logic               pop;
   logic               bit_done;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == DEPTH);
   assign push       = pif.print_valid && !fifo_full;
   assign pop        = (state == IDLE) && !fifo_empty;
   assign bit_done   = (baud_cnt == BAUD_MAX);

   // Storage needs no reset: pointers alone define valid entries.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= pif.print_value;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         drop_cnt <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (pif.print_valid && fifo_full && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 1'b1;
      end
   end

   // Line level and busy are registered alongside the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         uart_tx  <= 1'b1;
         tx_busy  <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         case (state)
            IDLE: begin
               uart_tx <= 1'b1;
               if (pop) begin
                  shift    <= mem[rd_ptr];
                  state    <= START;
                  uart_tx  <= 1'b0;
                  tx_busy  <= 1'b1;
                  baud_cnt <= '0;
               end
            end
            START: begin
               if (bit_done) begin
                  state    <= DATA;
                  bit_idx  <= '0;
                  baud_cnt <= '0;
                  uart_tx  <= shift[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state   <= STOP;
                     uart_tx <= 1'b1;
                  end else begin
                     shift   <= shift >> 1;
                     bit_idx <= bit_idx + 1'b1;
                     uart_tx <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_done) begin
                  state    <= IDLE;
                  tx_busy  <= 1'b0;
                  baud_cnt <= '0;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               uart_tx <= 1'b1;
               tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
